// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the RISC_TOY data-memory responder.
package toy_mem_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_CW = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE  = 2'b00;
  localparam err_code_t ERR_RANGE = 2'b01;
  localparam err_code_t ERR_BUSY  = 2'b10;

endpackage

// File: rtl/toy_sram_1p.sv
// Synchronous single-port word array, active-low select/write, 1-cycle read.
module toy_sram_1p #(
  parameter int AW = 10,
  parameter int BW = 32
) (
  input  logic          CLK,
  input  logic          CSN,
  input  logic          WEN,
  input  logic [AW-1:0] A,
  input  logic [BW-1:0] DI,
  output logic [BW-1:0] DOUT
);

  logic [BW-1:0] mem [0:(1<<AW)-1];

  // DOUT only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) mem[A] <= DI;
      else      DOUT   <= mem[A];
    end
  end

endmodule

// File: rtl/toy_dmem_responder.sv
// D-port responder: clear sweep FSM, core/loader arbitration onto one SRAM port,
// sticky error capture and saturating access counters.
module toy_dmem_responder
  import toy_mem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  input  logic          INIT_START,
  output logic          BUSY,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [31:0]   LD_DATA,
  output logic          LD_READY,
  input  logic          ERR_CLR,
  output logic          ERR,
  output logic [1:0]    ERR_CODE,
  output logic [29:0]   ERR_ADDR,
  output logic [CW-1:0] RD_CNT,
  output logic [CW-1:0] WR_CNT
);

  state_t        state;
  logic [AW-1:0] ptr;
  logic          in_range;
  logic          running;
  logic          core_rd;
  logic          core_wr;
  logic          ld_wr;
  logic          err_hit;
  err_code_t     err_new;
  logic          rd_zero;

  logic          sram_csn;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [31:0]   sram_di;
  logic [31:0]   sram_dout;

  assign in_range = (DADDR[29:AW] == '0);
  assign running  = (state == RUN);
  assign core_rd  = running & DREQ & in_range & ~DRW;
  assign core_wr  = running & DREQ & in_range & DRW;
  assign LD_READY = running & ~DREQ;
  assign ld_wr    = LD_EN & LD_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= CLEAR;
      ptr   <= '0;
      BUSY  <= 1'b1;
    end else if (INIT_START) begin
      state <= CLEAR;
      ptr   <= '0;
      BUSY  <= 1'b1;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (&ptr) begin
        state <= RUN;
        BUSY  <= 1'b0;
      end
    end
  end

  // Single SRAM port: sweep beats core, core beats loader.
  always_comb begin
    sram_csn = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_di  = '0;
    if (state == CLEAR) begin
      sram_csn = 1'b0;
      sram_wen = 1'b0;
      sram_a   = ptr;
    end else if (core_rd || core_wr) begin
      sram_csn = 1'b0;
      sram_wen = ~DRW;
      sram_a   = DADDR[AW-1:0];
      sram_di  = DWDATA;
    end else if (ld_wr) begin
      sram_csn = 1'b0;
      sram_wen = 1'b0;
      sram_a   = LD_ADDR;
      sram_di  = LD_DATA;
    end
  end

  toy_sram_1p #(.AW(AW), .BW(32)) u_sram (
    .CLK  (CLK),
    .CSN  (sram_csn),
    .WEN  (sram_wen),
    .A    (sram_a),
    .DI   (sram_di),
    .DOUT (sram_dout)
  );

  // The array output is not reset, so a flag masks it after reset and after
  // an out-of-range read; dropped busy accesses leave it untouched.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                          rd_zero <= 1'b1;
    else if (running && DREQ && !DRW)   rd_zero <= ~in_range;
  end

  assign DRDATA = rd_zero ? '0 : sram_dout;

  always_comb begin
    err_hit = 1'b0;
    err_new = ERR_NONE;
    if (DREQ) begin
      if (!running) begin
        err_hit = 1'b1;
        err_new = ERR_BUSY;
      end else if (!in_range) begin
        err_hit = 1'b1;
        err_new = ERR_RANGE;
      end
    end
  end

  // A new error arriving with ERR_CLR is captured rather than cleared.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
      ERR_ADDR <= '0;
    end else if (err_hit && (!ERR || ERR_CLR)) begin
      ERR      <= 1'b1;
      ERR_CODE <= err_new;
      ERR_ADDR <= DADDR;
    end else if (ERR_CLR) begin
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
      ERR_ADDR <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else if (INIT_START) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (core_rd && !(&RD_CNT)) RD_CNT <= RD_CNT + 1'b1;
      if (core_wr && !(&WR_CNT)) WR_CNT <= WR_CNT + 1'b1;
    end
  end

endmodule
